// File: rtl/imdct_rom_arb.sv
// imdct_rom_arb: two-requester arbiter in front of a shared quarter-wave
// IMDCT twiddle ROM (257 x 64-bit). Folds the 10-bit angle index onto the
// ROM, grants one lookup per cycle and returns the ROM word together with
// the fold flags through a fixed two-stage pipeline.
module imdct_rom_arb #(
    parameter bit FIXED_PRIO = 1'b0  // 0: round-robin, 1: requester 0 always wins
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic [9:0]  r0_idx,
    input  logic        r0_lock,
    input  logic        r1_req,
    input  logic [9:0]  r1_idx,
    input  logic        r1_lock,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic        rom_en,
    output logic [8:0]  rom_addr,
    input  logic [63:0] rom_dout,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_mirror,
    output logic        rsp_half
);

    // Quarter-wave fold: indices past 256 within a half period read backwards.
    function automatic logic [8:0] fold_addr(input logic [9:0] idx);
        logic [8:0] q;
        logic [9:0] back;
        q    = idx[8:0];
        back = 10'd512 - {1'b0, q};
        if (q <= 9'd256) begin
            return q;
        end
        return back[8:0];
    endfunction

    // Arbitration state: requester that received the most recent grant.
    logic        r_last;

    // Stage A: lookup metadata captured at the end of the grant cycle.
    logic        r_a_valid;
    logic        r_a_id;
    logic        r_a_mirror;
    logic        r_a_half;

    // Stage B: response registers (ROM word plus metadata).
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_hi;
    logic [31:0] r_rsp_lo;
    logic        r_rsp_mirror;
    logic        r_rsp_half;

    logic        w_hold0;
    logic        w_hold1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_en;
    logic [9:0]  w_sel_idx;
    logic [8:0]  w_sel_addr;
    logic        w_sel_mirror;
    logic        w_sel_half;

    // Grant decision: burst lock first, then fixed priority or round-robin.
    always_comb begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_hold0 = (r_last == 1'b0) && r0_req && r0_lock;
        w_hold1 = (r_last == 1'b1) && r1_req && r1_lock;
        // NOTE: rst_n gates the combinational grant so nothing is accepted
        // (and no ROM read issued) while reset is asserted.
        if (rst_n) begin
            if (w_hold0) begin
                w_gnt0 = 1'b1;
            end else if (w_hold1) begin
                w_gnt1 = 1'b1;
            end else if (FIXED_PRIO) begin
                w_gnt0 = r0_req;
                w_gnt1 = r1_req && !r0_req;
            end else if (r0_req && r1_req) begin
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
            end else begin
                w_gnt0 = r0_req;
                w_gnt1 = r1_req;
            end
        end
    end

    // Winner's index folded onto the ROM; address parks at 0 when idle.
    always_comb begin
        w_en         = w_gnt0 | w_gnt1;
        w_sel_idx    = w_gnt1 ? r1_idx : r0_idx;
        w_sel_addr   = fold_addr(w_sel_idx);
        w_sel_mirror = (w_sel_idx[8:0] > 9'd256);
        w_sel_half   = w_sel_idx[9];
    end

    // Round-robin pointer: moves on a grant, holds through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_en) begin
            r_last <= w_gnt1;
        end
    end

    // Stage A: remember which lookup the ROM is serving this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid  <= 1'b0;
            r_a_id     <= 1'b0;
            r_a_mirror <= 1'b0;
            r_a_half   <= 1'b0;
        end else begin
            r_a_valid <= w_en;
            if (w_en) begin
                r_a_id     <= w_gnt1;
                r_a_mirror <= w_sel_mirror;
                r_a_half   <= w_sel_half;
            end
        end
    end

    // Stage B: join ROM data with metadata; payload holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_hi     <= '0;
            r_rsp_lo     <= '0;
            r_rsp_mirror <= 1'b0;
            r_rsp_half   <= 1'b0;
        end else begin
            r_rsp_valid <= r_a_valid;
            if (r_a_valid) begin
                r_rsp_id     <= r_a_id;
                r_rsp_hi     <= rom_dout[63:32];
                r_rsp_lo     <= rom_dout[31:0];
                r_rsp_mirror <= r_a_mirror;
                r_rsp_half   <= r_a_half;
            end
        end
    end

    assign r0_gnt     = w_gnt0;
    assign r1_gnt     = w_gnt1;
    assign rom_en     = w_en;
    assign rom_addr   = w_en ? w_sel_addr : 9'd0;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_hi     = r_rsp_hi;
    assign rsp_lo     = r_rsp_lo;
    assign rsp_mirror = r_rsp_mirror;
    assign rsp_half   = r_rsp_half;

endmodule

// File: tb/tb_imdct_rom_arb.sv
// tb_imdct_rom_arb: runs a round-robin and a fixed-priority instance side by
// side on the same request stream, each with its own ROM model, and compares
// them cycle by cycle against a transaction-level reference model.
module tb_imdct_rom_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        r0_req, r1_req, r0_lock, r1_lock;
    logic [9:0]  r0_idx, r1_idx;

    logic        r0_gnt [2];
    logic        r1_gnt [2];
    logic        rom_en [2];
    logic [8:0]  rom_addr [2];
    logic [63:0] rom_dout [2];
    logic        rsp_valid [2];
    logic        rsp_id [2];
    logic [31:0] rsp_hi [2];
    logic [31:0] rsp_lo [2];
    logic        rsp_mirror [2];
    logic        rsp_half [2];

    logic [63:0] rom_mem [257];

    imdct_rom_arb #(.FIXED_PRIO(1'b0)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_idx(r0_idx), .r0_lock(r0_lock),
        .r1_req(r1_req), .r1_idx(r1_idx), .r1_lock(r1_lock),
        .r0_gnt(r0_gnt[0]), .r1_gnt(r1_gnt[0]),
        .rom_en(rom_en[0]), .rom_addr(rom_addr[0]), .rom_dout(rom_dout[0]),
        .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]),
        .rsp_hi(rsp_hi[0]), .rsp_lo(rsp_lo[0]),
        .rsp_mirror(rsp_mirror[0]), .rsp_half(rsp_half[0])
    );

    imdct_rom_arb #(.FIXED_PRIO(1'b1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_idx(r0_idx), .r0_lock(r0_lock),
        .r1_req(r1_req), .r1_idx(r1_idx), .r1_lock(r1_lock),
        .r0_gnt(r0_gnt[1]), .r1_gnt(r1_gnt[1]),
        .rom_en(rom_en[1]), .rom_addr(rom_addr[1]), .rom_dout(rom_dout[1]),
        .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]),
        .rsp_hi(rsp_hi[1]), .rsp_lo(rsp_lo[1]),
        .rsp_mirror(rsp_mirror[1]), .rsp_half(rsp_half[1])
    );

    // Synchronous ROM models: data valid the cycle after the read enable.
    always @(posedge clk) if (rom_en[0]) rom_dout[0] <= rom_mem[rom_addr[0]];
    always @(posedge clk) if (rom_en[1]) rom_dout[1] <= rom_mem[rom_addr[1]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one response record per accepted lookup.
    typedef struct {
        int          due;
        bit          id;
        bit          mirror;
        bit          half;
        logic [63:0] data;
    } rsp_t;

    rsp_t exp_q [2][$];
    rsp_t m_hold [2];
    bit   m_last [2];
    int   cyc = 0;

    // Last-sampled DUT values for directed spot checks.
    logic       s_gnt0 [2];
    logic       s_gnt1 [2];
    logic [8:0] s_addr [2];
    logic       s_valid [2];
    logic       s_id [2];
    logic [31:0] s_hi [2];

    function automatic logic [8:0] ref_addr(input logic [9:0] idx);
        int q;
        q = int'(idx) % 512;
        return (q <= 256) ? 9'(q) : 9'(512 - q);
    endfunction

    // Who should win this cycle (-1 = nobody), from the arbitration rules.
    function automatic int ref_winner(input int mode, input bit last);
        if (!rst_n) return -1;
        if (!last && r0_req && r0_lock) return 0;
        if (last && r1_req && r1_lock) return 1;
        if (r0_req && r1_req) return (mode == 1) ? 0 : (last ? 0 : 1);
        if (r0_req) return 0;
        if (r1_req) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            exp_q[m].delete();
            m_last[m] = 1'b1;
            m_hold[m].due    = 0;
            m_hold[m].id     = 1'b0;
            m_hold[m].mirror = 1'b0;
            m_hold[m].half   = 1'b0;
            m_hold[m].data   = '0;
        end
    endtask

    task automatic drive(input bit q0, input bit l0, input logic [9:0] i0,
                         input bit q1, input bit l1, input logic [9:0] i1);
        r0_req = q0; r0_lock = l0; r0_idx = i0;
        r1_req = q1; r1_lock = l1; r1_idx = i1;
    endtask

    // One clock cycle: check both instances mid-cycle, then advance.
    task automatic run_cycle();
        int w;
        rsp_t e;
        logic [9:0] widx;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            w = ref_winner(m, m_last[m]);
            widx = (w == 1) ? r1_idx : r0_idx;
            check($sformatf("gnt0_m%0d", m), 64'(r0_gnt[m]), 64'(w == 0));
            check($sformatf("gnt1_m%0d", m), 64'(r1_gnt[m]), 64'(w == 1));
            check($sformatf("rom_en_m%0d", m), 64'(rom_en[m]), 64'(w >= 0));
            check($sformatf("rom_addr_m%0d", m), 64'(rom_addr[m]),
                  (w >= 0) ? 64'(ref_addr(widx)) : 64'd0);
            if (exp_q[m].size() > 0 && exp_q[m][0].due == cyc) begin
                m_hold[m] = exp_q[m].pop_front();
                check($sformatf("rsp_valid_m%0d", m), 64'(rsp_valid[m]), 64'd1);
            end else begin
                check($sformatf("rsp_valid_m%0d", m), 64'(rsp_valid[m]), 64'd0);
            end
            check($sformatf("rsp_id_m%0d", m), 64'(rsp_id[m]), 64'(m_hold[m].id));
            check($sformatf("rsp_hi_m%0d", m), 64'(rsp_hi[m]), 64'(m_hold[m].data[63:32]));
            check($sformatf("rsp_lo_m%0d", m), 64'(rsp_lo[m]), 64'(m_hold[m].data[31:0]));
            check($sformatf("rsp_mirror_m%0d", m), 64'(rsp_mirror[m]), 64'(m_hold[m].mirror));
            check($sformatf("rsp_half_m%0d", m), 64'(rsp_half[m]), 64'(m_hold[m].half));
            s_gnt0[m] = r0_gnt[m]; s_gnt1[m] = r1_gnt[m]; s_addr[m] = rom_addr[m];
            s_valid[m] = rsp_valid[m]; s_id[m] = rsp_id[m]; s_hi[m] = rsp_hi[m];
            if (w >= 0) begin
                e.due    = cyc + 2;
                e.id     = (w == 1);
                e.mirror = (int'(widx) % 512) > 256;
                e.half   = widx >= 10'd512;
                e.data   = rom_mem[ref_addr(widx)];
                exp_q[m].push_back(e);
                m_last[m] = (w == 1);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Reset held across one full cycle, asserted just after a clock edge.
    task automatic reset_cycle();
        rst_n = 1'b0;
        model_reset();
        run_cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [9:0] rand_idx();
        logic [9:0] edges [8];
        edges = '{10'd0, 10'd256, 10'd257, 10'd511, 10'd512, 10'd768, 10'd769, 10'd1023};
        if ($urandom_range(3) == 0) return edges[$urandom_range(7)];
        return 10'($urandom);
    endfunction

    initial begin
        logic [9:0] fold_idx [6];
        logic [8:0] fold_addr [6];
        fold_idx  = '{10'd0, 10'd256, 10'd257, 10'd511, 10'd512, 10'd1023};
        fold_addr = '{9'd0, 9'd256, 9'd255, 9'd1, 9'd0, 9'd1};

        for (int i = 0; i < 257; i++) rom_mem[i] = {$urandom, $urandom};
        rom_dout[0] = '0;
        rom_dout[1] = '0;
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;

        // Reset with live requests: no grants, outputs cleared.
        drive(1, 1, 10'd5, 1, 1, 10'd700);
        run_cycle();
        check("rst_gnt0", 64'(s_gnt0[0]), 64'd0);
        run_cycle();
        rst_n = 1'b1;

        // Single lookup of index 300 right after release.
        drive(1, 0, 10'd300, 0, 0, 10'd0);
        run_cycle();
        check("single_gnt0", 64'(s_gnt0[0]), 64'd1);
        check("single_addr", 64'(s_addr[0]), 64'd212);
        drive(0, 0, 0, 0, 0, 0);
        run_cycle();
        run_cycle();
        check("single_valid", 64'(s_valid[0]), 64'd1);
        check("single_hi", 64'(s_hi[0]), 64'(rom_mem[212][63:32]));

        // Contention from reset: r0, r1, r0, r1 (round-robin), r0 always (fixed).
        reset_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, rand_idx(), 1, 0, rand_idx());
            run_cycle();
            check($sformatf("rr_seq%0d", k), 64'(s_gnt1[0]), 64'(k % 2));
            check($sformatf("fp_seq%0d", k), 64'(s_gnt0[1]), 64'd1);
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) run_cycle();

        // Lock: r1 granted, then holds through r0 contention for 3 cycles.
        drive(0, 0, 0, 1, 0, rand_idx());
        run_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, rand_idx(), 1, 1, rand_idx());
            run_cycle();
            check($sformatf("lock_hold%0d", k), 64'(s_gnt1[0]), 64'd1);
        end
        drive(1, 0, rand_idx(), 1, 0, rand_idx());
        run_cycle();
        check("lock_drop", 64'(s_gnt0[0]), 64'd1);

        // Fold boundaries.
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, fold_idx[k], 0, 0, 0);
            run_cycle();
            check($sformatf("fold_addr%0d", k), 64'(s_addr[0]), 64'(fold_addr[k]));
        end
        drive(0, 0, 0, 0, 0, 0);
        run_cycle();
        run_cycle();

        // Reset while a lookup is in flight.
        drive(0, 0, 0, 1, 0, 10'd400);
        run_cycle();
        run_cycle();
        drive(1, 0, 10'd600, 0, 0, 0);
        run_cycle();
        drive(0, 0, 0, 0, 0, 0);
        reset_cycle();
        drive(1, 0, rand_idx(), 1, 0, rand_idx());
        run_cycle();
        check("flight_valid", 64'(s_valid[0]), 64'd0);
        check("flight_hi", 64'(s_hi[0]), 64'd0);
        check("flight_first", 64'(s_gnt0[0]), 64'd1);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(9) < 6, $urandom_range(1), rand_idx(),
                  $urandom_range(9) < 6, $urandom_range(1), rand_idx());
            if ($urandom_range(299) == 0) reset_cycle();
            else run_cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
